// File: rtl/datapath_seq.sv
// Register-file datapath (A/B/C pipeline, shifter, ALU, {V,N,Z} status) stepped by an
// internal multicycle sequencer behind a start/busy/done handshake, plus a debug read port.
module datapath_seq #(
   parameter int W  = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic [1:0]    ALUop,
   input  logic [1:0]    shift,
   input  logic [RW-1:0] rn,
   input  logic [RW-1:0] rm,
   input  logic [RW-1:0] rd,
   input  logic [W-1:0]  imm,
   output logic          busy,
   output logic          done,
   output logic [2:0]    status,
   output logic [W-1:0]  C,
   input  logic [RW-1:0] dbg_num,
   output logic [W-1:0]  dbg_data
);

   localparam int NREG = 2 ** RW;

   localparam logic [1:0] MODE_RR  = 2'b00;
   localparam logic [1:0] MODE_RI  = 2'b01;
   localparam logic [1:0] MODE_MOV = 2'b10;
   localparam logic [1:0] MODE_CMP = 2'b11;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

   typedef enum logic [2:0] {IDLE, READA, READB, EXEC, WB} state_t;

   state_t state, next_state;

   logic [W-1:0]  regs [NREG];
   logic [W-1:0]  a_reg, b_reg;
   logic [1:0]    mode_q, op_q, shift_q;
   logic [RW-1:0] rn_q, rm_q, rd_q;
   logic [W-1:0]  imm_q;

   logic          accept, do_reada, do_readb, do_exec, do_wb, last_step;
   logic [W-1:0]  b_shifted, a_in, b_in, alu_res;
   logic [1:0]    op_eff;
   logic          ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The first state after accept depends on the live mode input; afterwards the latched mode steers.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               next_state = (mode == MODE_MOV) ? EXEC : READA;
            end
         end
         READA:   next_state = (mode_q == MODE_RI) ? EXEC : READB;
         READB:   next_state = EXEC;
         EXEC:    next_state = (mode_q == MODE_CMP) ? IDLE : WB;
         WB:      next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      accept    = (state == IDLE) && start;
      do_reada  = (state == READA);
      do_readb  = (state == READB);
      do_exec   = (state == EXEC);
      do_wb     = (state == WB);
      last_step = do_wb || (do_exec && (mode_q == MODE_CMP));
   end

   // Shifter and ALU; move-immediate forces a zero A operand and an ADD.
   always_comb begin
      b_shifted = b_reg;
      case (shift_q)
         2'b01:   b_shifted = {b_reg[W-2:0], 1'b0};
         2'b10:   b_shifted = {1'b0, b_reg[W-1:1]};
         2'b11:   b_shifted = {b_reg[W-1], b_reg[W-1:1]};
         default: b_shifted = b_reg;
      endcase

      a_in   = a_reg;
      b_in   = b_shifted;
      op_eff = op_q;
      if (mode_q == MODE_RI) begin
         b_in = imm_q;
      end else if (mode_q == MODE_MOV) begin
         a_in   = '0;
         b_in   = imm_q;
         op_eff = OP_ADD;
      end

      alu_res = '0;
      ovf     = 1'b0;
      case (op_eff)
         OP_ADD: begin
            alu_res = a_in + b_in;
            ovf     = (a_in[W-1] == b_in[W-1]) && (alu_res[W-1] != a_in[W-1]);
         end
         OP_SUB: begin
            alu_res = a_in - b_in;
            ovf     = (a_in[W-1] != b_in[W-1]) && (alu_res[W-1] != a_in[W-1]);
         end
         OP_AND:  alu_res = a_in & b_in;
         OP_NOT:  alu_res = ~b_in;
         default: alu_res = '0;
      endcase
   end

   // Datapath registers; busy/done are registered so they change on the same edge as the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         a_reg   <= '0;
         b_reg   <= '0;
         C       <= '0;
         status  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         mode_q  <= '0;
         op_q    <= '0;
         shift_q <= '0;
         rn_q    <= '0;
         rm_q    <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
      end else begin
         if (accept) begin
            mode_q  <= mode;
            op_q    <= ALUop;
            shift_q <= shift;
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
            imm_q   <= imm;
         end
         if (do_reada) begin
            a_reg <= regs[rn_q];
         end
         if (do_readb) begin
            b_reg <= regs[rm_q];
         end
         if (do_exec) begin
            C <= alu_res;
            if (mode_q != MODE_MOV) begin
               status <= {ovf, alu_res[W-1], (alu_res == '0)};
            end
         end
         if (do_wb) begin
            regs[rd_q] <= C;
         end
         busy <= (next_state != IDLE);
         done <= last_step;
      end
   end

   assign dbg_data = regs[dbg_num];

endmodule

// File: tb/tb_datapath_seq.sv
// Randomised and directed bench for datapath_seq against an arithmetic reference model,
// with a second W=8 instance for the narrow-width overflow case.
module tb_datapath_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode, alu_op, shift;
   logic [2:0]  rn, rm, rd, dbg_num;
   logic [15:0] imm;
   logic        busy, done;
   logic [2:0]  status;
   logic [15:0] c_out, dbg_data;

   logic        start8;
   logic [1:0]  mode8, alu_op8, shift8;
   logic [2:0]  rn8, rm8, rd8, dbg_num8;
   logic [7:0]  imm8;
   logic        busy8, done8;
   logic [2:0]  status8;
   logic [7:0]  c8, dbg_data8;

   int compared   = 0;
   int mismatched = 0;

   int regs_m [8];
   int c_m;
   int st_m;

   datapath_seq #(.W(16), .RW(3)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .ALUop(alu_op), .shift(shift),
      .rn(rn), .rm(rm), .rd(rd), .imm(imm), .busy(busy), .done(done), .status(status),
      .C(c_out), .dbg_num(dbg_num), .dbg_data(dbg_data)
   );

   datapath_seq #(.W(8), .RW(3)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .mode(mode8), .ALUop(alu_op8), .shift(shift8),
      .rn(rn8), .rm(rm8), .rd(rd8), .imm(imm8), .busy(busy8), .done(done8), .status(status8),
      .C(c8), .dbg_num(dbg_num8), .dbg_data(dbg_data8)
   );

   always #5 clk = ~clk;

   function automatic int to_s(int x, int w);
      return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
   endfunction

   function automatic int shifted(int b, int sh, int w);
      int s, q;
      case (sh)
         1: return (b * 2) % (1 << w);
         2: return b / 2;
         3: begin
            s = to_s(b, w);
            q = (s < 0) ? (s - 1) / 2 : s / 2;
            return (q < 0) ? q + (1 << w) : q;
         end
         default: return b;
      endcase
   endfunction

   task automatic alu_model(input int a, input int b, input int op, input int w,
                            output int res, output int v);
      int full, sr;
      sr = 0;
      case (op)
         0: begin full = a + b; sr = to_s(a, w) + to_s(b, w); end
         1: begin full = a - b; sr = to_s(a, w) - to_s(b, w); end
         2: full = a & b;
         default: full = ~b;
      endcase
      res = full & ((1 << w) - 1);
      v   = ((op < 2) && (sr > (1 << (w - 1)) - 1 || sr < -(1 << (w - 1)))) ? 1 : 0;
   endtask

   task automatic model_cmd(input int m, input int op, input int sh, input int n,
                            input int mm, input int d, input int im);
      int a, b, eop, res, v;
      a   = (m == 2) ? 0 : regs_m[n];
      b   = (m == 1 || m == 2) ? im : shifted(regs_m[mm], sh, 16);
      eop = (m == 2) ? 0 : op;
      alu_model(a, b, eop, 16, res, v);
      c_m = res;
      if (m != 2) st_m = (v << 2) | (((res >> 15) & 1) << 1) | ((res == 0) ? 1 : 0);
      if (m != 3) regs_m[d] = res;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) regs_m[i] = 0;
      c_m  = 0;
      st_m = 0;
   endtask

   task automatic read_reg(input int i, output logic [15:0] v);
      dbg_num = 3'(i);
      #1;
      v = dbg_data;
   endtask

   // Issues one command, scrambles the inputs after accept, and counts edges until done.
   task automatic run_cmd(input int m, input int op, input int sh, input int n, input int mm,
                          input int d, input int im, output int lat, output bit busy_ok);
      @(negedge clk);
      start = 1'b1; mode = 2'(m); alu_op = 2'(op); shift = 2'(sh);
      rn = 3'(n); rm = 3'(mm); rd = 3'(d); imm = 16'(im);
      @(posedge clk);
      #1;
      start = 1'b0;
      mode = 2'($urandom); alu_op = 2'($urandom); shift = 2'($urandom);
      rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom); imm = 16'($urandom);
      busy_ok = busy;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (!done && !busy) busy_ok = 1'b0;
      end
      if (done && busy) busy_ok = 1'b0;
      model_cmd(m, op, sh, n, mm, d, im);
   endtask

   task automatic test_reset();
      logic [15:0] v;
      reset = 1'b1; start = 1'b0; mode = '0; alu_op = '0; shift = '0;
      rn = '0; rm = '0; rd = '0; imm = '0; dbg_num = '0;
      start8 = 1'b0; mode8 = '0; alu_op8 = '0; shift8 = '0;
      rn8 = '0; rm8 = '0; rd8 = '0; imm8 = '0; dbg_num8 = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_handshake: busy=%0b done=%0b expected 0 0", busy, done);
      end
      compared++;
      if (status !== 3'b000 || c_out !== 16'h0) begin
         mismatched++;
         $display("FAIL reset_status_c: status=%b C=%h expected 000 0000", status, c_out);
      end
      for (int i = 0; i < 8; i++) begin
         read_reg(i, v);
         compared++;
         if (v !== 16'h0) begin
            mismatched++;
            $display("FAIL reset_reg%0d: got %h expected 0000", i, v);
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reg_reg();
      int lat;
      bit bok;
      logic [15:0] v;
      run_cmd(2, 0, 0, 0, 0, 0, 7, lat, bok);
      run_cmd(2, 0, 0, 0, 0, 1, 2, lat, bok);
      run_cmd(0, 0, 1, 0, 1, 2, 0, lat, bok);
      compared++;
      if (lat != 4 || !bok) begin
         mismatched++;
         $display("FAIL rr_latency: edges=%0d busy_ok=%0b expected 4 1", lat, bok);
      end
      compared++;
      if (c_out !== 16'h000B || status !== 3'b000) begin
         mismatched++;
         $display("FAIL rr_result: C=%h status=%b expected 000b 000", c_out, status);
      end
      read_reg(2, v);
      compared++;
      if (v !== 16'h000B) begin
         mismatched++;
         $display("FAIL rr_writeback: R2=%h expected 000b", v);
      end
   endtask

   task automatic test_compare();
      int lat;
      bit bok;
      logic [15:0] v;
      run_cmd(3, 1, 0, 0, 0, 5, 0, lat, bok);
      compared++;
      if (lat != 3 || !bok) begin
         mismatched++;
         $display("FAIL cmp_latency: edges=%0d busy_ok=%0b expected 3 1", lat, bok);
      end
      compared++;
      if (c_out !== 16'h0 || status !== 3'b001) begin
         mismatched++;
         $display("FAIL cmp_result: C=%h status=%b expected 0000 001", c_out, status);
      end
      for (int i = 0; i < 8; i++) begin
         read_reg(i, v);
         compared++;
         if (v !== 16'(regs_m[i])) begin
            mismatched++;
            $display("FAIL cmp_regs_r%0d: got %h expected %h", i, v, 16'(regs_m[i]));
         end
      end
   endtask

   task automatic test_overflow();
      int lat;
      bit bok;
      logic [15:0] v;
      run_cmd(2, 0, 0, 0, 0, 3, 16'h7FFF, lat, bok);
      run_cmd(1, 0, 0, 3, 0, 4, 1, lat, bok);
      compared++;
      if (lat != 3 || !bok) begin
         mismatched++;
         $display("FAIL ovf_latency: edges=%0d busy_ok=%0b expected 3 1", lat, bok);
      end
      read_reg(4, v);
      compared++;
      if (v !== 16'h8000 || status !== 3'b110) begin
         mismatched++;
         $display("FAIL ovf_result: R4=%h status=%b expected 8000 110", v, status);
      end
      run_cmd(2, 0, 0, 0, 0, 5, 0, lat, bok);
      compared++;
      if (lat != 2 || status !== 3'b110 || c_out !== 16'h0) begin
         mismatched++;
         $display("FAIL mov_holds_status: edges=%0d status=%b C=%h expected 2 110 0000",
                  lat, status, c_out);
      end
   endtask

   task automatic test_shift();
      int lat;
      bit bok;
      logic [15:0] v;
      run_cmd(2, 0, 0, 0, 0, 1, 16'h8004, lat, bok);
      run_cmd(0, 3, 3, 0, 1, 6, 0, lat, bok);
      read_reg(6, v);
      compared++;
      if (v !== 16'h3FFD) begin
         mismatched++;
         $display("FAIL shift_asr_not: R6=%h expected 3ffd", v);
      end
      run_cmd(0, 3, 2, 0, 1, 6, 0, lat, bok);
      read_reg(6, v);
      compared++;
      if (v !== 16'hBFFD || status !== 3'b010) begin
         mismatched++;
         $display("FAIL shift_lsr_not: R6=%h status=%b expected bffd 010", v, status);
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      logic [15:0] v;
      @(negedge clk);
      start = 1'b1; mode = 2'b00; alu_op = 2'b00; shift = 2'b00;
      rn = 3'd0; rm = 3'd1; rd = 3'd7; imm = 16'h0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; mode = 2'b10; rd = 3'd5; imm = 16'h1234;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      model_cmd(0, 0, 0, 0, 1, 7, 0);
      compared++;
      if (lat != 4) begin
         mismatched++;
         $display("FAIL busy_ignore_latency: edges=%0d expected 4", lat);
      end
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL busy_ignore_idle: busy=%0b expected 0", busy);
      end
      read_reg(5, v);
      compared++;
      if (v !== 16'(regs_m[5])) begin
         mismatched++;
         $display("FAIL busy_ignore_r5: got %h expected %h", v, 16'(regs_m[5]));
      end
      read_reg(7, v);
      compared++;
      if (v !== 16'(regs_m[7])) begin
         mismatched++;
         $display("FAIL busy_ignore_r7: got %h expected %h", v, 16'(regs_m[7]));
      end
   endtask

   task automatic test_back_to_back();
      int lat, ia, ib;
      logic [15:0] v;
      ia = $urandom_range(65535, 0);
      ib = $urandom_range(65535, 0);
      @(negedge clk);
      start = 1'b1; mode = 2'b10; alu_op = 2'b00; shift = 2'b00;
      rn = 3'd0; rm = 3'd0; rd = 3'd2; imm = 16'(ia);
      @(posedge clk);
      #1;
      mode = 2'b01; alu_op = 2'b00; rn = 3'd2; rd = 3'd3; imm = 16'(ib);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      model_cmd(2, 0, 0, 0, 0, 2, ia);
      compared++;
      if (lat != 2) begin
         mismatched++;
         $display("FAIL b2b_first_latency: edges=%0d expected 2", lat);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      compared++;
      if (busy !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_zero_gap: busy=%0b expected 1", busy);
      end
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      model_cmd(1, 0, 0, 2, 0, 3, ib);
      read_reg(3, v);
      compared++;
      if (lat != 3 || v !== 16'(regs_m[3]) || c_out !== 16'(c_m)) begin
         mismatched++;
         $display("FAIL b2b_second: edges=%0d R3=%h C=%h expected 3 %h %h",
                  lat, v, c_out, 16'(regs_m[3]), 16'(c_m));
      end
   endtask

   task automatic test_random();
      int m, op, sh, n, mm, d, im, lat, exp_lat;
      bit bok;
      logic [15:0] v;
      for (int k = 0; k < 40; k++) begin
         m  = $urandom_range(3, 0);
         op = $urandom_range(3, 0);
         sh = $urandom_range(3, 0);
         n  = $urandom_range(7, 0);
         mm = $urandom_range(7, 0);
         d  = $urandom_range(7, 0);
         im = (k % 5 == 0) ? 16'h7FFF + $urandom_range(2, 0) : $urandom_range(65535, 0);
         run_cmd(m, op, sh, n, mm, d, im, lat, bok);
         exp_lat = (m == 0) ? 4 : (m == 2) ? 2 : 3;
         compared++;
         if (lat != exp_lat || !bok) begin
            mismatched++;
            $display("FAIL rand%0d_latency: mode=%0d edges=%0d busy_ok=%0b expected %0d 1",
                     k, m, lat, bok, exp_lat);
         end
         read_reg(d, v);
         compared++;
         if (c_out !== 16'(c_m) || status !== 3'(st_m) || v !== 16'(regs_m[d])) begin
            mismatched++;
            $display("FAIL rand%0d_result: mode=%0d op=%0d C=%h status=%b R%0d=%h expected %h %b %h",
                     k, m, op, c_out, status, d, v, 16'(c_m), 3'(st_m), 16'(regs_m[d]));
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit bok;
      logic [15:0] v;
      @(negedge clk);
      start = 1'b1; mode = 2'b00; alu_op = 2'b00; shift = 2'b00;
      rn = 3'd1; rm = 3'd2; rd = 3'd0; imm = 16'h0;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || status !== 3'b000) begin
         mismatched++;
         $display("FAIL midreset_ctrl: busy=%0b done=%0b status=%b expected 0 0 000",
                  busy, done, status);
      end
      for (int i = 0; i < 8; i++) begin
         read_reg(i, v);
         compared++;
         if (v !== 16'h0) begin
            mismatched++;
            $display("FAIL midreset_reg%0d: got %h expected 0000", i, v);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      read_reg(0, v);
      compared++;
      if (v !== 16'h0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL midreset_no_wb: R0=%h busy=%0b expected 0000 0", v, busy);
      end
      run_cmd(2, 0, 0, 0, 0, 1, 16'h5A5A, lat, bok);
      read_reg(1, v);
      compared++;
      if (lat != 2 || !bok || v !== 16'h5A5A) begin
         mismatched++;
         $display("FAIL midreset_next_cmd: edges=%0d busy_ok=%0b R1=%h expected 2 1 5a5a",
                  lat, bok, v);
      end
   endtask

   task automatic test_width8();
      int lat;
      @(negedge clk);
      start8 = 1'b1; mode8 = 2'b10; alu_op8 = 2'b00; rd8 = 3'd3; imm8 = 8'h7F;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      @(negedge clk);
      start8 = 1'b1; mode8 = 2'b01; alu_op8 = 2'b00; rn8 = 3'd3; rd8 = 3'd4; imm8 = 8'h01;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      dbg_num8 = 3'd4;
      #1;
      compared++;
      if (lat != 3 || c8 !== 8'h80 || status8 !== 3'b110 || dbg_data8 !== 8'h80) begin
         mismatched++;
         $display("FAIL w8_overflow: edges=%0d C=%h status=%b R4=%h expected 3 80 110 80",
                  lat, c8, status8, dbg_data8);
      end
   endtask

   initial begin
      test_reset();
      test_reg_reg();
      test_compare();
      test_overflow();
      test_shift();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
